// File: rtl/fetch_stage.sv
// Y86-64 fetch stage: F_predPC register, PC select, byte-addressed instruction
// memory, field split, valP / predicted-PC computation and status classification.
module fetch_stage #(
  parameter int IMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        F_stall,
  input  logic [3:0]  M_icode,
  input  logic        M_Cnd,
  input  logic [63:0] M_valA,
  input  logic [3:0]  W_icode,
  input  logic [63:0] W_valM,
  input  logic        imem_we,
  input  logic [63:0] imem_waddr,
  input  logic [7:0]  imem_wdata,
  output logic [63:0] F_predPC,
  output logic [63:0] f_pc,
  output logic [3:0]  f_stat,
  output logic [3:0]  f_icode,
  output logic [3:0]  f_ifun,
  output logic [3:0]  f_rA,
  output logic [3:0]  f_rB,
  output logic [63:0] f_valC,
  output logic [63:0] f_valP,
  output logic [63:0] f_predPC
);

  localparam int         AW        = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;
  localparam logic [64:0] MEM_LIMIT = 65'(IMEM_BYTES);
  localparam logic [3:0] S_AOK     = 4'b1000;
  localparam logic [3:0] S_HLT     = 4'b0100;
  localparam logic [3:0] S_ADR     = 4'b0010;
  localparam logic [3:0] S_INS     = 4'b0001;

  logic [7:0]  r_imem [IMEM_BYTES];
  logic [63:0] r_F_predPC;

  logic [7:0]  w_byte [10];
  logic [9:0]  w_in_range;
  logic [3:0]  w_icode;
  logic [3:0]  w_ifun;
  logic        w_need_regids;
  logic        w_need_valC;
  logic [3:0]  w_last;
  logic [63:0] w_valC;
  logic [63:0] w_valP;
  logic        w_adr_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_F_predPC <= 64'h0;
    end else if (!F_stall) begin
      r_F_predPC <= f_predPC;
    end
  end

  always_ff @(posedge clk) begin
    if (imem_we && (imem_waddr < 64'(IMEM_BYTES))) begin
      r_imem[imem_waddr[AW-1:0]] <= imem_wdata;
    end
  end

  assign F_predPC = r_F_predPC;

  always_comb begin
    if (M_icode == 4'h7 && !M_Cnd) begin
      f_pc = M_valA;
    end else if (W_icode == 4'h9) begin
      f_pc = W_valM;
    end else begin
      f_pc = r_F_predPC;
    end
  end

  // The ten bytes an instruction can span; addresses are widened to 65 bits so
  // a PC near 2^64 never wraps back into the valid range.
  for (genvar k = 0; k < 10; k++) begin : g_bytes
    logic [64:0] w_addr;
    assign w_addr        = {1'b0, f_pc} + 65'(k);
    assign w_in_range[k] = w_addr < MEM_LIMIT;
    assign w_byte[k]     = w_in_range[k] ? r_imem[w_addr[AW-1:0]] : 8'h00;
  end

  assign w_icode       = w_byte[0][7:4];
  assign w_ifun        = w_byte[0][3:0];
  assign w_need_regids = w_icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
  assign w_need_valC   = w_icode inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
  // Offset of the instruction's last byte: 0, 1, 8 or 9.
  assign w_last        = {w_need_valC, 2'b00, w_need_regids};
  assign w_valC        = !w_need_valC ? 64'h0 :
                         w_need_regids ? {w_byte[9], w_byte[8], w_byte[7], w_byte[6],
                                          w_byte[5], w_byte[4], w_byte[3], w_byte[2]}
                                       : {w_byte[8], w_byte[7], w_byte[6], w_byte[5],
                                          w_byte[4], w_byte[3], w_byte[2], w_byte[1]};
  assign w_valP        = f_pc + 64'(w_last) + 64'h1;
  assign w_adr_err     = !w_in_range[0] || !w_in_range[w_last];

  always_comb begin
    f_stat   = S_AOK;
    f_icode  = w_icode;
    f_ifun   = w_ifun;
    f_rA     = w_need_regids ? w_byte[1][7:4] : 4'hF;
    f_rB     = w_need_regids ? w_byte[1][3:0] : 4'hF;
    f_valC   = w_valC;
    f_valP   = w_valP;
    f_predPC = (w_icode == 4'h7 || w_icode == 4'h8) ? w_valC : w_valP;
    if (w_adr_err) begin
      f_stat   = S_ADR;
      f_icode  = 4'h1;
      f_ifun   = 4'h0;
      f_rA     = 4'hF;
      f_rB     = 4'hF;
      f_valC   = 64'h0;
      f_valP   = f_pc;
      f_predPC = f_pc;
    end else if (w_icode > 4'hB) begin
      f_stat = S_INS;
    end else if (w_icode == 4'h0) begin
      f_stat = S_HLT;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: instruction-level reference model with a per-cycle
// compare process, directed literal checks, then randomized traffic.
module tb_fetch_stage;

  localparam int MEMB = 1024;

  logic        clk;
  logic        reset;
  logic        F_stall;
  logic [3:0]  M_icode;
  logic        M_Cnd;
  logic [63:0] M_valA;
  logic [3:0]  W_icode;
  logic [63:0] W_valM;
  logic        imem_we;
  logic [63:0] imem_waddr;
  logic [7:0]  imem_wdata;
  logic [63:0] F_predPC;
  logic [63:0] f_pc;
  logic [3:0]  f_stat;
  logic [3:0]  f_icode;
  logic [3:0]  f_ifun;
  logic [3:0]  f_rA;
  logic [3:0]  f_rB;
  logic [63:0] f_valC;
  logic [63:0] f_valP;
  logic [63:0] f_predPC;

  fetch_stage #(.IMEM_BYTES(MEMB)) dut (
    .clk(clk), .reset(reset), .F_stall(F_stall),
    .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valA(M_valA),
    .W_icode(W_icode), .W_valM(W_valM),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .F_predPC(F_predPC), .f_pc(f_pc), .f_stat(f_stat), .f_icode(f_icode),
    .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB), .f_valC(f_valC),
    .f_valP(f_valP), .f_predPC(f_predPC)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  typedef struct packed {
    logic [63:0] pc;
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
    logic [63:0] predPC;
  } exp_t;

  logic [7:0]  m_mem [MEMB];
  logic [63:0] m_pred;
  logic        cmp_en;
  int          n_chk;
  int          n_pass;

  function automatic logic [7:0] rd(input logic [64:0] a);
    if (a < 65'(MEMB)) return m_mem[a[9:0]];
    return 8'h00;
  endfunction

  function automatic exp_t model(input logic [63:0] pred);
    exp_t e;
    logic [7:0] b0;
    int regs, cw, len;
    logic [64:0] start;
    if (M_icode == 4'h7 && !M_Cnd) e.pc = M_valA;
    else if (W_icode == 4'h9)      e.pc = W_valM;
    else                           e.pc = pred;
    start   = {1'b0, e.pc};
    b0      = rd(start);
    e.icode = b0[7:4];
    e.ifun  = b0[3:0];
    regs    = (e.icode inside {2, 3, 4, 5, 6, 10, 11}) ? 1 : 0;
    cw      = (e.icode inside {3, 4, 5, 7, 8}) ? 1 : 0;
    len     = 1 + regs + 8 * cw;
    e.rA    = regs ? rd(start + 1) >> 4 : 4'hF;
    e.rB    = regs ? rd(start + 1) & 8'h0F : 4'hF;
    e.valC  = 64'h0;
    if (cw) for (int i = 0; i < 8; i++) e.valC |= 64'(rd(start + 65'(1 + regs + i))) << (8 * i);
    e.valP   = e.pc + 64'(len);
    e.predPC = (e.icode == 4'h7 || e.icode == 4'h8) ? e.valC : e.valP;
    if (start + 65'(len - 1) >= 65'(MEMB)) begin
      e.stat = 4'b0010; e.icode = 4'h1; e.ifun = 4'h0; e.rA = 4'hF; e.rB = 4'hF;
      e.valC = 64'h0; e.valP = e.pc; e.predPC = e.pc;
    end else if (e.icode > 4'hB) e.stat = 4'b0001;
    else if (e.icode == 4'h0)    e.stat = 4'b0100;
    else                         e.stat = 4'b1000;
    return e;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    e = model(m_pred);
    if (reset)         m_pred <= 64'h0;
    else if (!F_stall) m_pred <= e.predPC;
    if (imem_we && imem_waddr < 64'(MEMB)) m_mem[imem_waddr[9:0]] <= imem_wdata;
  end

  // Scoreboard
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (cmp_en) begin
      e = model(m_pred);
      chk("F_predPC", F_predPC, m_pred);
      chk("f_pc", f_pc, e.pc);
      chk("f_stat", 64'(f_stat), 64'(e.stat));
      chk("f_icode", 64'(f_icode), 64'(e.icode));
      chk("f_ifun", 64'(f_ifun), 64'(e.ifun));
      chk("f_rA", 64'(f_rA), 64'(e.rA));
      chk("f_rB", 64'(f_rB), 64'(e.rB));
      chk("f_valC", f_valC, e.valC);
      chk("f_valP", f_valP, e.valP);
      chk("f_predPC", f_predPC, e.predPC);
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [63:0] addr, input logic [7:0] data);
    imem_we = 1'b1; imem_waddr = addr; imem_wdata = data;
    tick();
    imem_we = 1'b0;
  endtask

  task automatic load(input logic [63:0] base, input logic [79:0] bytes, input int n);
    for (int i = 0; i < n; i++) wr(base + 64'(i), bytes[79 - 8 * i -: 8]);
  endtask

  initial begin
    n_chk = 0; n_pass = 0; cmp_en = 1'b0;
    reset = 1'b1; F_stall = 1'b0;
    M_icode = 4'h0; M_Cnd = 1'b0; M_valA = 64'h0;
    W_icode = 4'h0; W_valM = 64'h0;
    imem_we = 1'b0; imem_waddr = 64'h0; imem_wdata = 8'h00;

    for (int i = 0; i < MEMB; i++) wr(64'(i), 8'($urandom));
    cmp_en = 1'b1;

    // irmovq $8,%rbx under reset, then run and stall
    load(64'h0, 80'h30F3_0800_0000_0000_0000, 10);
    @(negedge clk);
    chk("lit_rst_F_predPC", F_predPC, 64'h0);
    chk("lit_irm_stat", 64'(f_stat), 64'h8);
    chk("lit_irm_icode", 64'(f_icode), 64'h3);
    chk("lit_irm_ifun", 64'(f_ifun), 64'h0);
    chk("lit_irm_rA", 64'(f_rA), 64'hF);
    chk("lit_irm_rB", 64'(f_rB), 64'h3);
    chk("lit_irm_valC", f_valC, 64'h8);
    chk("lit_irm_valP", f_valP, 64'd10);
    chk("lit_irm_predPC", f_predPC, 64'd10);
    reset = 1'b0;
    tick();
    @(negedge clk);
    chk("lit_run_F_predPC", F_predPC, 64'd10);
    F_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk("lit_stall_hold", F_predPC, 64'd10);
    end
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("lit_rst_over_stall", F_predPC, 64'h0);
    F_stall = 1'b0;

    // jmp 0x20 and PC-select priority
    load(64'h0, 80'h7020_0000_0000_0000_0000, 9);
    @(negedge clk);
    chk("lit_jmp_predPC", f_predPC, 64'h20);
    chk("lit_jmp_valP", f_valP, 64'h9);
    M_icode = 4'h7; M_Cnd = 1'b0; M_valA = 64'h9;
    @(negedge clk);
    chk("lit_mispred_pc", f_pc, 64'h9);
    W_icode = 4'h9; W_valM = 64'h40;
    @(negedge clk);
    chk("lit_m_over_w_pc", f_pc, 64'h9);
    M_icode = 4'h0;
    wr(64'h40, 8'h10);
    @(negedge clk);
    chk("lit_ret_pc", f_pc, 64'h40);
    chk("lit_ret_icode", 64'(f_icode), 64'h1);
    chk("lit_ret_valP", f_valP, 64'h41);
    chk("lit_ret_stat", 64'(f_stat), 64'h8);
    W_icode = 4'h0;

    // Status classes
    wr(64'h0, 8'hC0);
    @(negedge clk);
    chk("lit_ins_stat", 64'(f_stat), 64'h1);
    chk("lit_ins_valP", f_valP, 64'h1);
    wr(64'h0, 8'h00);
    @(negedge clk);
    chk("lit_hlt_stat", 64'(f_stat), 64'h4);
    chk("lit_hlt_icode", 64'(f_icode), 64'h0);
    wr(64'(MEMB - 2), 8'h30);
    M_icode = 4'h7; M_Cnd = 1'b0; M_valA = 64'(MEMB - 2);
    @(negedge clk);
    chk("lit_adr_stat", 64'(f_stat), 64'h2);
    chk("lit_adr_icode", 64'(f_icode), 64'h1);
    chk("lit_adr_rA", 64'(f_rA), 64'hF);
    chk("lit_adr_rB", 64'(f_rB), 64'hF);
    chk("lit_adr_valP", f_valP, 64'(MEMB - 2));
    chk("lit_adr_predPC", f_predPC, 64'(MEMB - 2));

    // Write/read ordering and out-of-range write
    wr(64'h5, 8'h10);
    M_valA = 64'h5;
    imem_we = 1'b1; imem_waddr = 64'h5; imem_wdata = 8'hAB;
    @(negedge clk);
    chk("lit_wr_old_icode", 64'(f_icode), 64'h1);
    tick();
    imem_we = 1'b0;
    @(negedge clk);
    chk("lit_wr_new_icode", 64'(f_icode), 64'hA);
    chk("lit_wr_new_ifun", 64'(f_ifun), 64'hB);
    M_valA = 64'h0;
    wr(64'(MEMB), 8'hFF);
    @(negedge clk);
    chk("lit_oob_wr_icode", 64'(f_icode), 64'h0);
    chk("lit_oob_wr_stat", 64'(f_stat), 64'h4);
    M_icode = 4'h0;

    // Randomized traffic against the model
    reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      reset   = ($urandom_range(0, 49) == 0);
      F_stall = ($urandom_range(0, 4) == 0);
      M_icode = ($urandom_range(0, 3) == 0) ? 4'h7 : 4'($urandom_range(0, 15));
      M_Cnd   = 1'($urandom);
      M_valA  = ($urandom_range(0, 19) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, MEMB + 8));
      W_icode = ($urandom_range(0, 5) == 0) ? 4'h9 : 4'($urandom_range(0, 8));
      W_valM  = ($urandom_range(0, 19) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : 64'($urandom_range(0, MEMB + 8));
      imem_we = ($urandom_range(0, 3) == 0);
      imem_waddr = ($urandom_range(0, 9) == 0) ? 64'($urandom_range(MEMB, MEMB + 40))
                                               : 64'($urandom_range(0, MEMB - 1));
      imem_wdata = 8'($urandom);
      tick();
    end
    imem_we = 1'b0;
    @(negedge clk);
    cmp_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
